// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, issues a request-to-send,
// shifts a byte plus odd parity on device clock edges and collects the device acknowledge.
// Optional macro PS2_HOST_TX_GLITCH_FILTER_EN adds an 8-sample debounce on the clock line.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6500,
  parameter int TIMEOUT_CYCLES = 130000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       kclk_in,
  input  logic       kdata_in,
  output logic       kclk_oe,
  output logic       kdata_oe,
  output logic       done,
  output logic       ack,
  output logic       timeout
);

  localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] INH_END  = CW'(INHIBIT_CYCLES);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [3:0]    bit_cnt_reg;
  logic [7:0]    data_reg;
  logic          kclk_oe_reg;
  logic          kdata_oe_reg;
  logic          done_reg;
  logic          ack_reg;
  logic          timeout_reg;
  logic          tx_ready_reg;

  logic [1:0]    kclk_sync_reg;
  logic [1:0]    kdata_sync_reg;
  logic          kclk_prev_reg;
  logic          kclk_level;
  logic          kdata_level;
  logic          kclk_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kclk_sync_reg  <= 2'b11;
      kdata_sync_reg <= 2'b11;
    end else begin
      kclk_sync_reg  <= {kclk_sync_reg[0], kclk_in};
      kdata_sync_reg <= {kdata_sync_reg[0], kdata_in};
    end
  end

  assign kdata_level = kdata_sync_reg[1];

`ifdef PS2_HOST_TX_GLITCH_FILTER_EN
  logic       kclk_filt_reg;
  logic [2:0] filt_cnt_reg;

  // The filtered level only follows the pin after 8 consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kclk_filt_reg <= 1'b1;
      filt_cnt_reg  <= 3'd0;
    end else if (kclk_sync_reg[1] == kclk_filt_reg) begin
      filt_cnt_reg <= 3'd0;
    end else if (filt_cnt_reg == 3'd7) begin
      kclk_filt_reg <= kclk_sync_reg[1];
      filt_cnt_reg  <= 3'd0;
    end else begin
      filt_cnt_reg <= filt_cnt_reg + 3'd1;
    end
  end

  assign kclk_level = kclk_filt_reg;
`else
  assign kclk_level = kclk_sync_reg[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kclk_prev_reg <= 1'b1;
    end else begin
      kclk_prev_reg <= kclk_level;
    end
  end

  assign kclk_fall = kclk_prev_reg & ~kclk_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      bit_cnt_reg  <= 4'd0;
      data_reg     <= 8'h00;
      kclk_oe_reg  <= 1'b0;
      kdata_oe_reg <= 1'b0;
      done_reg     <= 1'b0;
      ack_reg      <= 1'b0;
      timeout_reg  <= 1'b0;
      tx_ready_reg <= 1'b1;
    end else begin
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (tx_valid) begin
            data_reg     <= tx_data;
            state_reg    <= INHIBIT;
            cnt_reg      <= '0;
            kclk_oe_reg  <= 1'b1;
            kdata_oe_reg <= 1'b0;
            tx_ready_reg <= 1'b0;
            ack_reg      <= 1'b0;
          end
        end

        // Clock held low for the inhibit time, then one cycle of start bit with clock released.
        INHIBIT: begin
          if (cnt_reg == INH_END) begin
            state_reg <= REQ;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == INH_LAST) begin
              kclk_oe_reg  <= 1'b0;
              kdata_oe_reg <= 1'b1;
            end
          end
        end

        default: begin
          // Device-clocked phases share one watchdog; a falling edge always restarts it.
          if (!kclk_fall && cnt_reg == TO_LAST && !done_reg) begin
            timeout_reg  <= 1'b1;
            state_reg    <= IDLE;
            kclk_oe_reg  <= 1'b0;
            kdata_oe_reg <= 1'b0;
            tx_ready_reg <= 1'b1;
          end else begin
            cnt_reg <= kclk_fall ? '0 : cnt_reg + 1'b1;
            case (state_reg)
              REQ: begin
                if (kclk_fall) begin
                  state_reg    <= SHIFT;
                  bit_cnt_reg  <= 4'd1;
                  kdata_oe_reg <= ~data_reg[0];
                end
              end
              SHIFT: begin
                if (kclk_fall) begin
                  if (bit_cnt_reg == 4'd9) begin
                    kdata_oe_reg <= 1'b0;
                    state_reg    <= ACK;
                  end else begin
                    bit_cnt_reg <= bit_cnt_reg + 4'd1;
                    // Odd parity bit is ~^data, so the line is pulled low when ^data is 1.
                    if (bit_cnt_reg == 4'd8) begin
                      kdata_oe_reg <= ^data_reg;
                    end else begin
                      kdata_oe_reg <= ~data_reg[bit_cnt_reg[2:0]];
                    end
                  end
                end
              end
              ACK: begin
                if (kclk_fall) begin
                  ack_reg   <= ~kdata_level;
                  state_reg <= WAIT_IDLE;
                end
              end
              WAIT_IDLE: begin
                if (done_reg) begin
                  state_reg    <= IDLE;
                  tx_ready_reg <= 1'b1;
                end else if (kclk_level && kdata_level) begin
                  done_reg <= 1'b1;
                end
              end
              default: begin
                state_reg    <= IDLE;
                kclk_oe_reg  <= 1'b0;
                kdata_oe_reg <= 1'b0;
                tx_ready_reg <= 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign tx_ready = tx_ready_reg;
  assign kclk_oe  = kclk_oe_reg;
  assign kdata_oe = kdata_oe_reg;
  assign done     = done_reg;
  assign ack      = ack_reg;
  assign timeout  = timeout_reg;

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The block SHALL have parameter INHIBIT_CYCLES, default 6500, clock-low inhibit time in clk cycles (100 us at 65 MHz).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 130000, maximum clk cycles allowed between device clock falling edges (2 ms at 65 MHz).
REQ-003 The block SHALL have port clk  input  1  system clock, all logic on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have ports tx_valid  input  1  command request; tx_data  input  8  command byte; tx_ready  output  1  block can accept a byte.
REQ-006 The block SHALL have ports kclk_in  input  1  PS/2 clock pin level; kdata_in  input  1  PS/2 data pin level; both asynchronous.
REQ-007 The block SHALL have ports kclk_oe  output  1  1 = drive PS/2 clock low; kdata_oe  output  1  1 = drive PS/2 data low; 0 = release (pull-up).
REQ-008 The block SHALL have ports done  output  1  one-cycle end-of-transfer pulse; ack  output  1  device acknowledge, valid while done=1; timeout  output  1  one-cycle error pulse.

Function
REQ-009 kclk_in and kdata_in SHALL each pass a 2-flop synchronizer; a falling edge is synced previous=1, current=0.
REQ-010 tx_ready SHALL be 1 only in state IDLE; a byte SHALL be accepted and latched when tx_valid=1 and tx_ready=1; tx_valid while not IDLE SHALL be ignored.
REQ-011 States SHALL be IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE.
REQ-012 IDLE -> INHIBIT on accept; INHIBIT SHALL hold kclk_oe=1, kdata_oe=0 for INHIBIT_CYCLES cycles, then assert kdata_oe=1 (start bit) for one cycle, then enter REQ.
REQ-013 REQ SHALL hold kclk_oe=0, kdata_oe=1; the first kclk falling edge SHALL enter SHIFT with edge count 1.
REQ-014 On falling edge n=1..8 in SHIFT, data line SHALL present tx_data[n-1] (LSB first, kdata_oe = ~bit); edge 9 SHALL present odd parity (~^tx_data); edge 10 SHALL release data (stop bit) and enter ACK.
REQ-015 In ACK the next falling edge SHALL sample synced kdata: ack=1 if low, 0 if high; then enter WAIT_IDLE.
REQ-016 WAIT_IDLE SHALL wait until synced kclk=1 and kdata=1, then pulse done with ack held, and return to IDLE the next cycle.
REQ-017 A timeout counter SHALL clear on each kclk falling edge and on entry to REQ; in REQ/SHIFT/ACK/WAIT_IDLE reaching TIMEOUT_CYCLES SHALL pulse timeout, release both lines, and go to IDLE without pulsing done.
REQ-018 kclk_oe SHALL be 1 only in INHIBIT; outside INHIBIT/REQ/SHIFT kdata_oe SHALL be 0.
REQ-019 Counter widths SHALL be $clog2 of the larger parameter plus 1; no wrap before terminal count.

Reset
REQ-020 rst_n=0 SHALL asynchronously force IDLE, kclk_oe=0, kdata_oe=0, done=0, ack=0, timeout=0, tx_ready=1 after release, counters and synchronizer flops to their idle values (sync flops to 1).
REQ-021 Reset asserted mid-transfer SHALL abandon the byte with no done or timeout pulse; the first accept after reset SHALL start a fresh INHIBIT.

Configuration
REQ-022 With macro PS2_HOST_TX_GLITCH_FILTER_EN defined, synced kclk SHALL update only after 8 consecutive equal samples (edge detection delayed 8 cycles); without it, edge detection SHALL use the 2-flop output directly.

Verification (bench INHIBIT_CYCLES=20, TIMEOUT_CYCLES=200, device model clock period 40 cycles)
REQ-023 tx_data=0xED accepted -> kclk_oe high 20 cycles, start 0, device samples bits 1,0,1,1,0,1,1,1, parity 1, stop 1; model acks -> done=1, ack=1.
REQ-024 tx_data=0x01 with model not acking (data high at edge 11) -> parity sampled 0, done=1 with ack=0.
REQ-025 Model stops clocking after edge 4 -> timeout=1 exactly 200 cycles after edge 4, kclk_oe=kdata_oe=0, tx_ready=1, no done.
REQ-026 rst_n pulsed low at edge 6 of 0xFF -> lines released immediately, no done/timeout; new 0x00 transfer completes with parity 1 and ack=1.
REQ-027 tx_valid held high during transfer with changing tx_data -> transmitted byte is the value latched at accept; second byte starts only after done.
REQ-028 With PS2_HOST_TX_GLITCH_FILTER_EN, 3-cycle low glitches on kclk during SHIFT -> no extra bits counted; 0xED transfer still correct.
